mesh_result_drain: RTL

MESH_RESULT_DRAIN -- requirements
Module: mesh_result_drain

---
 rtl/mesh_result_drain.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mesh_result_drain.sv
// mesh_result_drain: drains one accumulator result per PE from an NxN mesh,
// visiting PEs in row-major order and presenting each result on a
// valid/ready stream.
// Optional feature macro: DRAIN_TIMEOUT_EN. When it is defined, a PE that
// stays non-idle or never pulses accumulator_valid_i for TIMEOUT_CYCLES
// cycles yields a quiet-NaN result flagged with result_err_o.
module mesh_result_drain #(
    parameter int N              = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 start_i,
    input  logic [N*N-1:0]                       pe_idle_i,
    input  logic [N*N-1:0]                       accumulator_valid_i,
    input  logic [N*N*DATA_WIDTH-1:0]            acc_data_i,
    output logic [N*N-1:0]                       select_accumulator_o,
    output logic [DATA_WIDTH-1:0]                result_data_o,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] result_row_o,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] result_col_o,
    output logic                                 result_err_o,
    output logic                                 result_valid_o,
    input  logic                                 result_ready_i,
    output logic                                 busy_o,
    output logic                                 done_o
);

    localparam int NN    = N * N;
    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
    localparam int RC_W  = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NN - 1);
    localparam logic [RC_W-1:0]       LAST_COL = RC_W'(N - 1);
    localparam logic [DATA_WIDTH-1:0] QNAN     = DATA_WIDTH'(32'h7FC0_0000);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_SELECT,
        ST_WAIT_VALID,
        ST_OUTPUT,
        ST_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [IDX_W-1:0]      r_idx;
    logic [RC_W-1:0]       r_cur_row;
    logic [RC_W-1:0]       r_cur_col;
    logic [DATA_WIDTH-1:0] r_data;
    logic [RC_W-1:0]       r_row;
    logic [RC_W-1:0]       r_col;

    logic [NN-1:0]         w_onehot;
    logic [DATA_WIDTH-1:0] w_acc_cur;
    logic                  w_idle_cur;
    logic                  w_valid_cur;
    logic                  w_tmo_hit;
    logic                  w_start;
    logic                  w_capture;
    logic                  w_timeout;
    logic                  w_advance;

    // Decode the current PE index into a one-hot mask and pick its data slice
    always_comb begin
        w_onehot  = '0;
        w_acc_cur = '0;
        for (int i = 0; i < NN; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_onehot[i] = 1'b1;
                w_acc_cur   = acc_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Only the flags of the PE being drained matter; all other bits are masked
    assign w_idle_cur  = |(pe_idle_i & w_onehot);
    assign w_valid_cur = |(accumulator_valid_i & w_onehot);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and the one-cycle event strobes for the datapath
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_start      = 1'b1;
                    w_state_next = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (w_idle_cur) begin
                    w_state_next = ST_SELECT;
                end else if (w_tmo_hit) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_OUTPUT;
                end
            end
            ST_SELECT: begin
                w_state_next = ST_WAIT_VALID;
            end
            ST_WAIT_VALID: begin
                if (w_valid_cur) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_OUTPUT;
                end else if (w_tmo_hit) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (result_ready_i) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = ST_WAIT_IDLE;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // PE walk counters plus the captured result, held until accepted
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idx     <= '0;
            r_cur_row <= '0;
            r_cur_col <= '0;
            r_data    <= '0;
            r_row     <= '0;
            r_col     <= '0;
        end else begin
            if (w_start) begin
                r_idx     <= '0;
                r_cur_row <= '0;
                r_cur_col <= '0;
            end else if (w_advance) begin
                r_idx <= r_idx + IDX_W'(1);
                if (r_cur_col == LAST_COL) begin
                    r_cur_col <= '0;
                    r_cur_row <= r_cur_row + RC_W'(1);
                end else begin
                    r_cur_col <= r_cur_col + RC_W'(1);
                end
            end
            if (w_capture || w_timeout) begin
                r_row <= r_cur_row;
                r_col <= r_cur_col;
            end
            if (w_capture) begin
                r_data <= w_acc_cur;
            end else if (w_timeout) begin
                r_data <= QNAN;
            end
        end
    end

`ifdef DRAIN_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_err;

    // Cycles spent in the current wait state; restarts on every state change
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tmo_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_WAIT_IDLE || r_state == ST_WAIT_VALID) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Error flag marks results substituted after a timeout
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_capture) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign result_err_o = r_err;
`else
    // Without the timeout feature the drain waits forever on each PE
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
    assign w_tmo_hit    = 1'b0;
    assign result_err_o = 1'b0;
`endif

    assign select_accumulator_o = (r_state == ST_SELECT || r_state == ST_WAIT_VALID) ? w_onehot : '0;
    assign result_data_o        = r_data;
    assign result_row_o         = r_row;
    assign result_col_o         = r_col;
    assign result_valid_o       = (r_state == ST_OUTPUT);
    assign busy_o               = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done_o               = (r_state == ST_DONE);

endmodule
